// File: rtl/aead_seq_ctrl.sv
// aead_seq_ctrl -- job sequencer in front of chacha20_poly1305_core.
//
// Takes one AEAD job descriptor and drives the core through the job:
// configure, request keystream, forward the AAD and payload block streams
// with byte-keep masks, send the length block, then collect the tag.
//
// Parameters
//   LEN_W   width of aad_len / pld_len (at most 64, at least 5)
//   TO_CYC  watchdog limit, in cycles spent in WAIT_TAG
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   start, key, nonce, ctr_init,   job descriptor, latched on start in IDLE
//   aad_len, pld_len
//   in_valid, in_data, in_ready    upstream blocks: AAD first, then payload
//   abort                          synchronous job abort
//   busy, done, err, tag           status and final tag
//   c_*                            core-side control and data
//
// Optional feature (macro AEAD_TAG_CHECK_EN):
//   adds exp_tag (latched on start) and tag_ok (tag == exp_tag, valid with done).
//
// States
//   IDLE     | waiting for start
//   CFG      | c_cfg_we pulse
//   KSREQ    | c_ks_req pulse
//   AAD      | AAD blocks pass through to the core
//   PLD      | payload blocks pass through to the core
//   LEN      | length block offered until accepted
//   WAIT_TAG | collecting tag_pre_xor and tagmask, watchdog running
//   FIN      | tag valid, done pulse

module aead_seq_ctrl #(
    parameter int LEN_W  = 16,
    parameter int TO_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [255:0]     key,
    input  logic [95:0]      nonce,
    input  logic [31:0]      ctr_init,
    input  logic [LEN_W-1:0] aad_len,
    input  logic [LEN_W-1:0] pld_len,
`ifdef AEAD_TAG_CHECK_EN
    input  logic [127:0]     exp_tag,
    output logic             tag_ok,
`endif
    input  logic             in_valid,
    input  logic [127:0]     in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [127:0]     tag,
    output logic [255:0]     c_key,
    output logic [95:0]      c_nonce,
    output logic [31:0]      c_ctr_init,
    output logic             c_cfg_we,
    output logic             c_ks_req,
    output logic             c_aad_valid,
    output logic [127:0]     c_aad_data,
    output logic [15:0]      c_aad_keep,
    output logic             c_pld_valid,
    output logic [127:0]     c_pld_data,
    output logic [15:0]      c_pld_keep,
    output logic             c_len_valid,
    output logic [127:0]     c_len_block,
    output logic             c_algo_sel,
    input  logic             c_aad_ready,
    input  logic             c_pld_ready,
    input  logic             c_len_ready,
    input  logic [127:0]     c_tag_pre_xor,
    input  logic             c_tag_pre_xor_valid,
    input  logic [127:0]     c_tagmask,
    input  logic             c_tagmask_valid
);

    localparam int WD_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_KSREQ, S_AAD, S_PLD, S_LEN, S_WAIT_TAG, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [LEN_W-1:0]  aad_len_q, pld_len_q;
    logic [255:0]      key_q;
    logic [95:0]       nonce_q;
    logic [31:0]       ctr_q;
    logic              have_pre_q, have_mask_q;
    logic [127:0]      pre_q, mask_q, tag_q;
    logic              err_q;
    logic              timeout, tag_done;
    logic              last_beat;
    logic [15:0]       keep_last, data_keep;
    logic [LEN_W-1:0]  rem_sat;
    logic              got_pre, got_mask;
    logic [127:0]      tag_xor;
`ifdef AEAD_TAG_CHECK_EN
    logic [127:0]      exp_tag_q;
    logic              tag_ok_q;
`endif

    // rem_q holds the bytes still owed in the current data phase, so the
    // current beat is the last one once no more than a full block remains.
    assign last_beat = (rem_q <= LEN_W'(16));
    assign keep_last = (rem_q[3:0] == 4'd0) ? 16'hffff
                                            : ((16'h0001 << rem_q[3:0]) - 16'h0001);
    assign data_keep = last_beat ? keep_last : 16'hffff;
    assign rem_sat   = (rem_q > LEN_W'(16)) ? (rem_q - LEN_W'(16)) : '0;

    // A tag half arriving in the final cycle counts together with a
    // previously captured one, so FIN follows the last valid directly.
    assign got_pre  = have_pre_q  | c_tag_pre_xor_valid;
    assign got_mask = have_mask_q | c_tagmask_valid;
    assign tag_xor  = (have_pre_q  ? pre_q  : c_tag_pre_xor) ^
                      (have_mask_q ? mask_q : c_tagmask);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        wd_d        = wd_q;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        in_ready    = 1'b0;
        c_cfg_we    = 1'b0;
        c_ks_req    = 1'b0;
        c_aad_valid = 1'b0;
        c_pld_valid = 1'b0;
        c_len_valid = 1'b0;
        timeout     = 1'b0;
        tag_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CFG;
            end
            S_CFG: begin
                c_cfg_we = 1'b1;
                state_d  = S_KSREQ;
            end
            S_KSREQ: begin
                c_ks_req = 1'b1;
                if (aad_len_q != '0) begin
                    state_d = S_AAD;
                    rem_d   = aad_len_q;
                end else if (pld_len_q != '0) begin
                    state_d = S_PLD;
                    rem_d   = pld_len_q;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_AAD: begin
                c_aad_valid = in_valid;
                in_ready    = c_aad_ready;
                if (in_valid && c_aad_ready) begin
                    rem_d = rem_sat;
                    if (last_beat) begin
                        if (pld_len_q != '0) begin
                            state_d = S_PLD;
                            rem_d   = pld_len_q;
                        end else begin
                            state_d = S_LEN;
                        end
                    end
                end
            end
            S_PLD: begin
                c_pld_valid = in_valid;
                in_ready    = c_pld_ready;
                if (in_valid && c_pld_ready) begin
                    rem_d = rem_sat;
                    if (last_beat) state_d = S_LEN;
                end
            end
            S_LEN: begin
                c_len_valid = 1'b1;
                if (c_len_ready) begin
                    state_d = S_WAIT_TAG;
                    wd_d    = WD_W'(TO_CYC - 1);
                end
            end
            S_WAIT_TAG: begin
                if (got_pre && got_mask) begin
                    state_d  = S_FIN;
                    tag_done = 1'b1;
                end else if (wd_q == '0) begin
                    state_d = S_IDLE;
                    timeout = 1'b1;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            done     = 1'b0;
            timeout  = 1'b0;
            tag_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            wd_q        <= '0;
            aad_len_q   <= '0;
            pld_len_q   <= '0;
            key_q       <= '0;
            nonce_q     <= '0;
            ctr_q       <= '0;
            have_pre_q  <= 1'b0;
            have_mask_q <= 1'b0;
            pre_q       <= '0;
            mask_q      <= '0;
            tag_q       <= '0;
            err_q       <= 1'b0;
`ifdef AEAD_TAG_CHECK_EN
            exp_tag_q   <= '0;
            tag_ok_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wd_q    <= wd_d;
            err_q   <= timeout;
            if (state_q == S_IDLE && start) begin
                aad_len_q <= aad_len;
                pld_len_q <= pld_len;
                key_q     <= key;
                nonce_q   <= nonce;
                ctr_q     <= ctr_init;
`ifdef AEAD_TAG_CHECK_EN
                exp_tag_q <= exp_tag;
`endif
            end
            // Captures only persist while we stay in WAIT_TAG; anything
            // seen in other states is dropped.
            if (state_q == S_WAIT_TAG && state_d == S_WAIT_TAG) begin
                if (c_tag_pre_xor_valid) begin
                    pre_q      <= c_tag_pre_xor;
                    have_pre_q <= 1'b1;
                end
                if (c_tagmask_valid) begin
                    mask_q      <= c_tagmask;
                    have_mask_q <= 1'b1;
                end
            end else begin
                have_pre_q  <= 1'b0;
                have_mask_q <= 1'b0;
            end
            if (tag_done) begin
                tag_q <= tag_xor;
`ifdef AEAD_TAG_CHECK_EN
                tag_ok_q <= (tag_xor == exp_tag_q);
`endif
            end
        end
    end

    assign err         = err_q;
    assign tag         = tag_q;
    assign c_key       = key_q;
    assign c_nonce     = nonce_q;
    assign c_ctr_init  = ctr_q;
    assign c_aad_data  = in_data;
    assign c_pld_data  = in_data;
    assign c_aad_keep  = data_keep;
    assign c_pld_keep  = data_keep;
    assign c_algo_sel  = 1'b1;
    assign c_len_block = {{(64-LEN_W){1'b0}}, aad_len_q, {(64-LEN_W){1'b0}}, pld_len_q};
`ifdef AEAD_TAG_CHECK_EN
    assign tag_ok      = tag_ok_q;
`endif

endmodule

// File: tb/tb_aead_seq_ctrl.sv
module tb_aead_seq_ctrl;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] key = '0;
    logic [95:0]  nonce = '0;
    logic [31:0]  ctr_init = '0;
    logic [15:0]  aad_len = '0, pld_len = '0;
    logic [127:0] exp_tag = '0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready;
    logic         abort = 1'b0;
    logic         busy, done, err;
    logic [127:0] tag;
    logic [255:0] c_key;
    logic [95:0]  c_nonce;
    logic [31:0]  c_ctr_init;
    logic         c_cfg_we, c_ks_req;
    logic         c_aad_valid, c_pld_valid, c_len_valid, c_algo_sel;
    logic [127:0] c_aad_data, c_pld_data, c_len_block;
    logic [15:0]  c_aad_keep, c_pld_keep;
    logic         c_aad_ready = 1'b0, c_pld_ready = 1'b0, c_len_ready = 1'b0;
    logic [127:0] c_tag_pre_xor = '0, c_tagmask = '0;
    logic         c_tag_pre_xor_valid = 1'b0, c_tagmask_valid = 1'b0;
`ifdef AEAD_TAG_CHECK_EN
    logic         tag_ok;
`endif

    always #5 clk = ~clk;

    aead_seq_ctrl #(.LEN_W(16), .TO_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce),
        .ctr_init(ctr_init), .aad_len(aad_len), .pld_len(pld_len),
`ifdef AEAD_TAG_CHECK_EN
        .exp_tag(exp_tag), .tag_ok(tag_ok),
`endif
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .abort(abort), .busy(busy), .done(done), .err(err), .tag(tag),
        .c_key(c_key), .c_nonce(c_nonce), .c_ctr_init(c_ctr_init),
        .c_cfg_we(c_cfg_we), .c_ks_req(c_ks_req),
        .c_aad_valid(c_aad_valid), .c_aad_data(c_aad_data), .c_aad_keep(c_aad_keep),
        .c_pld_valid(c_pld_valid), .c_pld_data(c_pld_data), .c_pld_keep(c_pld_keep),
        .c_len_valid(c_len_valid), .c_len_block(c_len_block), .c_algo_sel(c_algo_sel),
        .c_aad_ready(c_aad_ready), .c_pld_ready(c_pld_ready), .c_len_ready(c_len_ready),
        .c_tag_pre_xor(c_tag_pre_xor), .c_tag_pre_xor_valid(c_tag_pre_xor_valid),
        .c_tagmask(c_tagmask), .c_tagmask_valid(c_tagmask_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk1(input string name, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int nblk(input int len);
        return (len + 15) / 16;
    endfunction

    function automatic logic [15:0] last_keep(input int len);
        int r;
        r = len % 16;
        if (r == 0) return 16'hffff;
        return 16'((1 << r) - 1);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_CFG, M_KS, M_AAD, M_PLD, M_LEN, M_WT, M_FIN} mph_t;
    mph_t         mph = M_IDLE;
    logic [255:0] m_key = '0;
    logic [95:0]  m_nonce = '0;
    logic [31:0]  m_ctr = '0;
    int           m_aad = 0, m_pld = 0, m_bi = 0, m_wt = 0;
    bit           m_hp = 0, m_hm = 0;
    logic [127:0] m_pre = '0, m_mask = '0, m_tag = '0, m_exp = '0;
    logic         m_err = 1'b0, m_tag_ok = 1'b0;

    // observations used by the literal pins
    int           obs_aad = 0, obs_pld = 0, obs_len_cyc = -1, obs_rdy_cyc = -1, start_cyc = 0;
    logic [15:0]  obs_aad_keep = '0;
    logic [15:0]  obs_keeps[$];
    logic [127:0] obs_len_block = '0;

    always @(negedge clk) begin
        logic        exp_ir;
        logic [15:0] ek;
        logic [127:0] ptag;
        bit          hp, hm;
        cyc++;
        exp_ir = (mph == M_AAD) ? c_aad_ready : (mph == M_PLD) ? c_pld_ready : 1'b0;
        chk1("busy", busy, mph != M_IDLE);
        chk1("cfg_we", c_cfg_we, mph == M_CFG);
        chk1("ks_req", c_ks_req, mph == M_KS);
        chk1("in_ready", in_ready, exp_ir);
        chk1("aad_valid", c_aad_valid, (mph == M_AAD) && in_valid);
        chk1("pld_valid", c_pld_valid, (mph == M_PLD) && in_valid);
        chk1("len_valid", c_len_valid, mph == M_LEN);
        chk1("done", done, (mph == M_FIN) && !abort);
        chk1("err", err, m_err);
        chk1("algo_sel", c_algo_sel, 1'b1);
        chkw("tag", 256'(tag), 256'(m_tag));
        chkw("key", c_key, m_key);
        chkw("nonce", 256'(c_nonce), 256'(m_nonce));
        chkw("ctr", 256'(c_ctr_init), 256'(m_ctr));
`ifdef AEAD_TAG_CHECK_EN
        chk1("tag_ok", tag_ok, m_tag_ok);
`endif
        if (mph == M_LEN || !rst_n)
            chkw("len_block", 256'(c_len_block),
                 {128'd0, 64'(m_aad), 64'(m_pld)});
        if (mph == M_AAD) begin
            chkw("aad_data", 256'(c_aad_data), 256'(in_data));
            if (in_valid && c_aad_ready) begin
                ek = (m_bi == nblk(m_aad) - 1) ? last_keep(m_aad) : 16'hffff;
                chkw("aad_keep", 256'(c_aad_keep), 256'(ek));
                obs_aad++;
                obs_aad_keep = c_aad_keep;
            end
        end
        if (mph == M_PLD) begin
            chkw("pld_data", 256'(c_pld_data), 256'(in_data));
            if (in_valid && c_pld_ready) begin
                ek = (m_bi == nblk(m_pld) - 1) ? last_keep(m_pld) : 16'hffff;
                chkw("pld_keep", 256'(c_pld_keep), 256'(ek));
                obs_pld++;
                obs_keeps.push_back(c_pld_keep);
            end
        end
        if (c_len_valid && obs_len_cyc < 0) begin
            obs_len_cyc   = cyc;
            obs_len_block = c_len_block;
        end
        if (in_ready && obs_rdy_cyc < 0) obs_rdy_cyc = cyc;

        // advance the model to what the coming edge must produce
        m_err = 1'b0;
        if (!rst_n) begin
            mph = M_IDLE; m_key = '0; m_nonce = '0; m_ctr = '0; m_aad = 0; m_pld = 0;
            m_tag = '0; m_tag_ok = 1'b0; m_exp = '0; m_hp = 0; m_hm = 0;
        end else if (mph != M_IDLE && abort) begin
            mph = M_IDLE;
        end else begin
            case (mph)
                M_IDLE: if (start) begin
                    mph = M_CFG; m_key = key; m_nonce = nonce; m_ctr = ctr_init;
                    m_aad = int'(aad_len); m_pld = int'(pld_len); m_exp = exp_tag;
                    start_cyc = cyc;
                end
                M_CFG: mph = M_KS;
                M_KS: begin
                    m_bi = 0;
                    mph = (m_aad != 0) ? M_AAD : (m_pld != 0) ? M_PLD : M_LEN;
                end
                M_AAD: if (in_valid && c_aad_ready) begin
                    m_bi++;
                    if (m_bi == nblk(m_aad)) begin
                        m_bi = 0;
                        mph = (m_pld != 0) ? M_PLD : M_LEN;
                    end
                end
                M_PLD: if (in_valid && c_pld_ready) begin
                    m_bi++;
                    if (m_bi == nblk(m_pld)) mph = M_LEN;
                end
                M_LEN: if (c_len_ready) begin
                    mph = M_WT; m_wt = 0; m_hp = 0; m_hm = 0;
                end
                M_WT: begin
                    hp = m_hp; hm = m_hm;
                    if (c_tag_pre_xor_valid) begin m_pre = c_tag_pre_xor; hp = 1; end
                    if (c_tagmask_valid)     begin m_mask = c_tagmask;    hm = 1; end
                    m_hp = hp; m_hm = hm;
                    m_wt++;
                    if (hp && hm) begin
                        ptag = m_pre ^ m_mask;
                        m_tag = ptag;
                        m_tag_ok = (ptag == m_exp);
                        mph = M_FIN;
                    end else if (m_wt == TO) begin
                        m_err = 1'b1;
                        mph = M_IDLE;
                    end
                end
                M_FIN: mph = M_IDLE;
                default: mph = M_IDLE;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    logic [127:0] last_tag = '0;

    task automatic obs_clear();
        obs_aad = 0; obs_pld = 0; obs_len_cyc = -1; obs_rdy_cyc = -1;
        obs_keeps.delete();
    endtask

    task automatic run_job(input int aad, input int pld, input bit stall, input bit no_tag,
                           input int abort_at, input bit flip_exp, input bit stray);
        int guard = 0;
        int pld_seen = 0;
        bit len_hs = 0;
        bit aborted = 0;
        bit hs;
        int k, d1, d2, dm;
        logic [127:0] pre, mask;
        pre  = rand128();
        mask = rand128();
        obs_clear();
        @(posedge clk); #1;
        start = 1'b1;
        key = {rand128(), rand128()};
        nonce = 96'(rand128());
        ctr_init = $urandom();
        aad_len = 16'(aad);
        pld_len = 16'(pld);
        exp_tag = flip_exp ? ((pre ^ mask) ^ 128'd1) : (pre ^ mask);
        in_data = rand128();
        @(posedge clk); #1;
        start = 1'b0;
        key = {rand128(), rand128()};
        nonce = 96'(rand128());
        ctr_init = $urandom();
        while (!len_hs && !aborted && guard < 400) begin
            in_valid    = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            c_aad_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            c_pld_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            c_len_ready = stall ? ($urandom_range(0, 1) == 0) : 1'b1;
            abort = (abort_at >= 0) && (pld_seen == abort_at) && c_pld_valid;
            c_tag_pre_xor_valid = stray && c_pld_valid;
            c_tag_pre_xor = rand128();
            @(negedge clk);
            hs = in_valid && in_ready;
            if (c_pld_valid && c_pld_ready) pld_seen++;
            if (c_len_valid && c_len_ready) len_hs = 1;
            if (abort) aborted = 1;
            @(posedge clk); #1;
            if (hs) in_data = rand128();
            abort = 1'b0;
            c_tag_pre_xor_valid = 1'b0;
            guard++;
        end
        in_valid = 1'b0;
        c_len_ready = 1'b0;
        if (aborted) begin
            @(negedge clk);
            chk1("abort_busy", busy, 1'b0);
            chk1("abort_pld_valid", c_pld_valid, 1'b0);
            chk1("abort_len_valid", c_len_valid, 1'b0);
            repeat (TO + 3) @(negedge clk);
            return;
        end
        if (!len_hs) begin
            n_checks++; n_fail++;
            $display("FAIL job_progress: no length handshake within %0d cycles", guard);
            return;
        end
        c_tag_pre_xor = pre;
        c_tagmask     = mask;
        if (no_tag) begin
            for (k = 1; k <= 30; k++) begin
                @(negedge clk);
                if (err) break;
            end
            chkw("timeout_latency", 256'(k), 256'(TO + 1));
            chk1("timeout_busy", busy, 1'b0);
            chkw("timeout_tag_kept", 256'(tag), 256'(last_tag));
            return;
        end
        d1 = $urandom_range(0, 3);
        d2 = $urandom_range(0, 3);
        dm = (d1 > d2) ? d1 : d2;
        for (k = 0; k <= dm; k++) begin
            c_tag_pre_xor_valid = (k == d1);
            c_tagmask_valid     = (k == d2);
            @(posedge clk); #1;
        end
        c_tag_pre_xor_valid = 1'b0;
        c_tagmask_valid     = 1'b0;
        @(negedge clk);
        chk1("done_after_tags", done, 1'b1);
        chkw("tag_value", 256'(tag), 256'(pre ^ mask));
`ifdef AEAD_TAG_CHECK_EN
        chk1("tag_ok_value", tag_ok, !flip_exp);
`endif
        last_tag = pre ^ mask;
        @(negedge clk);
        chk1("busy_after_fin", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit st, fl, sy;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // aligned lengths, no stalls, stray tag during payload
        run_job(16, 64, 0, 0, -1, 0, 1);
        chkw("j1_aad_beats", 256'(obs_aad), 256'(1));
        chkw("j1_aad_keep", 256'(obs_aad_keep), 256'(16'hffff));
        chkw("j1_pld_beats", 256'(obs_pld), 256'(4));
        chkw("j1_pld_keep_last", 256'(obs_keeps[3]), 256'(16'hffff));
        chkw("j1_len_block", 256'(obs_len_block), 256'(128'h0000000000000010_0000000000000040));
        chkw("j1_first_data_cyc", 256'(obs_rdy_cyc - start_cyc), 256'(3));

        // AAD skipped, partial last payload block
        run_job(0, 20, 0, 0, -1, 1, 0);
        chkw("j2_aad_beats", 256'(obs_aad), 256'(0));
        chkw("j2_pld_beats", 256'(obs_pld), 256'(2));
        chkw("j2_keep0", 256'(obs_keeps[0]), 256'(16'hffff));
        chkw("j2_keep1", 256'(obs_keeps[1]), 256'(16'h000f));
        chkw("j2_len_block", 256'(obs_len_block), 256'(128'd20));

        // empty job goes straight to LEN
        run_job(0, 0, 0, 0, -1, 0, 0);
        chkw("j3_len_cyc", 256'(obs_len_cyc - start_cyc), 256'(3));
        chkw("j3_len_block", 256'(obs_len_block), 256'(0));

        // stalls on both sides
        run_job(37, 100, 1, 0, -1, 0, 0);
        chkw("j4_aad_beats", 256'(obs_aad), 256'(3));
        chkw("j4_aad_keep_last", 256'(obs_aad_keep), 256'(16'h001f));
        chkw("j4_pld_beats", 256'(obs_pld), 256'(7));
        chkw("j4_pld_keep_last", 256'(obs_keeps[6]), 256'(16'h000f));

        // tags never arrive, then a fresh job
        run_job(5, 5, 0, 1, -1, 0, 0);
        run_job(33, 0, 0, 0, -1, 0, 0);
        chkw("j6_aad_beats", 256'(obs_aad), 256'(3));

        // abort during the second payload beat
        run_job(0, 64, 0, 0, 1, 0, 0);
        run_job(0, 16, 0, 0, -1, 0, 0);

        for (int j = 0; j < 6; j++) begin
            st = ($urandom_range(0, 1) == 1);
            fl = ($urandom_range(0, 1) == 1);
            sy = ($urandom_range(0, 1) == 1);
            run_job(int'($urandom_range(0, 80)), int'($urandom_range(0, 80)), st, 0, -1, fl, sy);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
